cordic_rotation_engine: RTL

CORDIC_ROTATION_ENGINE -- requirements
Module: cordic_rotation_engine

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_sat.sv | 26 ++
 rtl/cordic_rotation_engine.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table in quarter-turn units (0x4000 = 90 deg),
// gain-compensation constant and the engine state encoding.
package cordic_pkg;

   localparam int          NATAN     = 15;
   localparam logic [15:0] ATAN [0:NATAN-1] = '{
      16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
      16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1
   };
   localparam logic [15:0] CORDIC_K  = 16'd19898;
   localparam logic [15:0] ANG90     = 16'h4000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      COMP = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [15:0] atan_lut(input logic [3:0] i);
      return (i < 4'(NATAN)) ? ATAN[i] : 16'd0;
   endfunction

endpackage

// File: rtl/cordic_sat.sv
// Narrows a wide signed value to OW bits, clamping to the signed range and flagging the clamp.
module cordic_sat #(
   parameter int IW = 18,
   parameter int OW = 16
) (
   input  logic signed [IW-1:0] i_val,
   output logic signed [OW-1:0] o_val,
   output logic                 o_sat
);

   localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   always_comb begin
      o_sat = 1'b0;
      o_val = i_val[OW-1:0];
      if (i_val > MAXV) begin
         o_val = {1'b0, {(OW-1){1'b1}}};
         o_sat = 1'b1;
      end else if (i_val < MINV) begin
         o_val = {1'b1, {(OW-1){1'b0}}};
         o_sat = 1'b1;
      end
   end

endmodule

// File: rtl/cordic_rotation_engine.sv
// Iterative CORDIC rotation, one micro-rotation per cycle, result held until out_ready.
// Optional unity-gain output stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_rotation_engine
   import cordic_pkg::*;
#(
   parameter int FRAC_BITS = 15,
   parameter int ITERS     = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [FRAC_BITS:0] x_in,
   input  logic signed [FRAC_BITS:0] y_in,
   input  logic        [FRAC_BITS:0] theta_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [FRAC_BITS:0] x_out,
   output logic signed [FRAC_BITS:0] y_out,
   output logic                  sat
);

   localparam int W  = FRAC_BITS + 1;
   localparam int XW = FRAC_BITS + 3;
   localparam int ZW = FRAC_BITS + 2;
   localparam logic [W-1:0] QMASK = W'(ANG90 - 16'd1);

   state_t               r_state;
   logic [3:0]           r_cnt;
   logic signed [XW-1:0] r_x, r_y;
   logic signed [ZW-1:0] r_z;
   logic signed [W-1:0]  r_x_out, r_y_out;
   logic                 r_sat;

   logic signed [XW-1:0] w_xs, w_ys, w_x_nxt, w_y_nxt, w_x_fin, w_y_fin;
   logic signed [ZW-1:0] w_z_nxt, w_atan;
   logic signed [W-1:0]  w_x_sat, w_y_sat;
   logic                 w_x_clip, w_y_clip;

   // Both axes update from the pre-cycle values; direction follows the residual angle sign.
   always_comb begin
      w_xs   = r_x >>> r_cnt;
      w_ys   = r_y >>> r_cnt;
      w_atan = ZW'(atan_lut(r_cnt));
      if (!r_z[ZW-1]) begin
         w_x_nxt = r_x - w_ys;
         w_y_nxt = r_y + w_xs;
         w_z_nxt = r_z - w_atan;
      end else begin
         w_x_nxt = r_x + w_ys;
         w_y_nxt = r_y - w_xs;
         w_z_nxt = r_z + w_atan;
      end
   end

`ifdef CORDIC_GAIN_COMP_EN
   localparam int PW = XW + 17;
   localparam logic signed [PW-1:0] RND = PW'(2 ** (FRAC_BITS - 1));
   logic signed [PW-1:0] w_xp, w_yp;

   always_comb begin
      w_xp    = PW'(r_x) * PW'($signed({1'b0, CORDIC_K})) + RND;
      w_yp    = PW'(r_y) * PW'($signed({1'b0, CORDIC_K})) + RND;
      w_x_fin = XW'(w_xp >>> FRAC_BITS);
      w_y_fin = XW'(w_yp >>> FRAC_BITS);
   end
`else
   assign w_x_fin = w_x_nxt;
   assign w_y_fin = w_y_nxt;
`endif

   cordic_sat #(.IW(XW), .OW(W)) u_sat_x (.i_val(w_x_fin), .o_val(w_x_sat), .o_sat(w_x_clip));
   cordic_sat #(.IW(XW), .OW(W)) u_sat_y (.i_val(w_y_fin), .o_val(w_y_sat), .o_sat(w_y_clip));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_x_out <= '0;
         r_y_out <= '0;
         r_sat   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_x     <= XW'(x_in);
               r_y     <= XW'(y_in);
               r_z     <= {1'b0, theta_in & QMASK};
               r_cnt   <= '0;
               r_state <= ITER;
            end
            ITER: begin
               r_x   <= w_x_nxt;
               r_y   <= w_y_nxt;
               r_z   <= w_z_nxt;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'(ITERS - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                  r_state <= COMP;
`else
                  r_state <= DONE;
                  r_x_out <= w_x_sat;
                  r_y_out <= w_y_sat;
                  r_sat   <= w_x_clip | w_y_clip;
`endif
               end
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
               r_state <= DONE;
               r_x_out <= w_x_sat;
               r_y_out <= w_y_sat;
               r_sat   <= w_x_clip | w_y_clip;
            end
`endif
            DONE: if (out_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign x_out     = r_x_out;
   assign y_out     = r_y_out;
   assign sat       = r_sat;

endmodule
